fft_dif_sequencer: RTL and testbench

Stage/butterfly scheduler for the in-place radix-2 decimation-in-frequency FFT. After a start pulse, it walks all SIZE stages. For each butterfly it issues one dual-port read (top and bottom address) and a twiddle index. Write-back addresses come out LATENCY cycles later, and the sequencer stalls between stages until the butterfly pipeline has drained. It sits between the input loader (which raises start) and the output address generator (which consumes done).

---
 rtl/fft_pkg.sv | 29 ++
 rtl/fft_bfly_delay.sv | 32 +++
 rtl/fft_dif_sequencer.sv | 152 +++++++++++++++
 tb/tb_fft_dif_sequencer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared definitions for the radix-2 FFT address blocks: default geometry,
// sequencer state encoding and the bit-insertion address helper.
`timescale 1ns/1ps
package fft_pkg;

    localparam int N_DEF       = 16;
    localparam int SIZE_DEF    = 4;
    localparam int LATENCY_DEF = 3;

    // Fixed working width for address helpers; covers SIZE up to 15 plus the inserted bit.
    localparam int ADDR_MAX = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } fsm_state_t;

    function automatic logic [ADDR_MAX-1:0] insert_zero_bit(
        input logic [ADDR_MAX-1:0] val,
        input logic [4:0]          pos
    );
        logic [ADDR_MAX-1:0] low_mask;
        low_mask = (ADDR_MAX'(1) << pos) - ADDR_MAX'(1);
        return ((val >> pos) << (pos + 5'd1)) | (val & low_mask);
    endfunction

endpackage

// File: rtl/fft_bfly_delay.sv
// Fixed-depth shift register that mirrors the butterfly pipeline so read
// issues re-emerge as write-backs; a synchronous flush drops all in-flight entries.
`timescale 1ns/1ps
module fft_bfly_delay #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] pipe [DEPTH];

    // NOTE: this array is reset (unlike a RAM) because it carries the write
    // enable; a stale entry after reset would cause a spurious write-back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= din;
            for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign dout = pipe[DEPTH-1];

endmodule

// File: rtl/fft_dif_sequencer.sv
// In-place radix-2 DIF FFT scheduler: walks every stage, issues one butterfly
// read per cycle, and drains the butterfly pipeline between stages.
`timescale 1ns/1ps
module fft_dif_sequencer
    import fft_pkg::*;
#(
    parameter int N       = N_DEF,
    parameter int SIZE    = SIZE_DEF,
    parameter int LATENCY = LATENCY_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    output logic            busy,
    output logic            rd_en,
    output logic [SIZE-1:0] rd_addr_a,
    output logic [SIZE-1:0] rd_addr_b,
    output logic [SIZE-2:0] tw_idx,
    output logic [3:0]      stage,
    output logic            last_stage,
    output logic            wr_en,
    output logic [SIZE-1:0] wr_addr_a,
    output logic [SIZE-1:0] wr_addr_b,
    output logic            done
);

    localparam int              DW         = $clog2(LATENCY + 1);
    localparam int              PIPE_W     = 2 * SIZE + 1;
    localparam logic [SIZE-2:0] CNT_LAST   = (SIZE-1)'(N / 2 - 1);
    localparam logic [3:0]      STAGE_LAST = 4'(SIZE - 1);
    localparam logic [DW-1:0]   DRAIN_LAST = DW'(LATENCY - 1);

    fsm_state_t      state;
    logic [SIZE-2:0] cnt;
    logic [DW-1:0]   drain_cnt;

    // NOTE: all state and registered outputs use non-blocking assignments so
    // every register sees the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            stage      <= '0;
            cnt        <= '0;
            drain_cnt  <= '0;
            busy       <= 1'b0;
            rd_en      <= 1'b0;
            last_stage <= 1'b0;
            done       <= 1'b0;
        end else if (abort) begin
            state      <= IDLE;
            stage      <= '0;
            cnt        <= '0;
            drain_cnt  <= '0;
            busy       <= 1'b0;
            rd_en      <= 1'b0;
            last_stage <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= RUN;
                        stage      <= '0;
                        cnt        <= '0;
                        busy       <= 1'b1;
                        rd_en      <= 1'b1;
                        last_stage <= 1'b0;
                    end
                end
                RUN: begin
                    cnt <= cnt + (SIZE-1)'(1);
                    if (cnt == CNT_LAST) begin
                        state     <= DRAIN;
                        rd_en     <= 1'b0;
                        drain_cnt <= '0;
                    end
                end
                DRAIN: begin
                    drain_cnt <= drain_cnt + DW'(1);
                    // Last write-back of this stage lands now; next read may follow.
                    if (drain_cnt == DRAIN_LAST) begin
                        if (stage == STAGE_LAST) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state      <= RUN;
                            stage      <= stage + 4'd1;
                            cnt        <= '0;
                            rd_en      <= 1'b1;
                            last_stage <= (stage + 4'd1 == STAGE_LAST);
                        end
                    end
                end
                DONE: begin
                    state      <= IDLE;
                    done       <= 1'b0;
                    busy       <= 1'b0;
                    last_stage <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic [4:0]          bit_pos;
    logic [ADDR_MAX-1:0] cnt_ext;
    logic [ADDR_MAX-1:0] span;
    logic [ADDR_MAX-1:0] addr_full;
    logic [ADDR_MAX-1:0] tw_full;

    // NOTE: every output of this block is given a default first so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        bit_pos   = 5'(SIZE - 1) - {1'b0, stage};
        cnt_ext   = ADDR_MAX'(cnt);
        span      = ADDR_MAX'(1) << bit_pos;
        addr_full = insert_zero_bit(cnt_ext, bit_pos);
        tw_full   = (cnt_ext & (span - ADDR_MAX'(1))) << stage;
        rd_addr_a = '0;
        rd_addr_b = '0;
        tw_idx    = '0;
        if (rd_en) begin
            rd_addr_a = addr_full[SIZE-1:0];
            rd_addr_b = addr_full[SIZE-1:0] | span[SIZE-1:0];
            tw_idx    = tw_full[SIZE-2:0];
        end
    end

    // Upper bits of the fixed-width helper results are zero by construction.
    logic unused_upper;
    assign unused_upper = ^{addr_full[ADDR_MAX-1:SIZE], span[ADDR_MAX-1:SIZE],
                            tw_full[ADDR_MAX-1:SIZE-1]};

    logic [PIPE_W-1:0] wr_bus;

    fft_bfly_delay #(
        .WIDTH (PIPE_W),
        .DEPTH (LATENCY)
    ) u_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (abort),
        .din   ({rd_en, rd_addr_a, rd_addr_b}),
        .dout  (wr_bus)
    );

    assign wr_en     = wr_bus[PIPE_W-1];
    assign wr_addr_a = wr_bus[2*SIZE-1:SIZE];
    assign wr_addr_b = wr_bus[SIZE-1:0];

endmodule

// File: tb/tb_fft_dif_sequencer.sv
// Self-checking bench for fft_dif_sequencer: per-cycle comparison against a
// schedule model derived from time arithmetic, plus abort/reset/restart scenarios.
`timescale 1ns/1ps
module tb_fft_dif_sequencer;

    localparam int SZ    = 4;
    localparam int NN    = 16;
    localparam int LAT   = 3;
    localparam int HALF  = NN / 2;
    localparam int PER   = HALF + LAT;
    localparam int TDONE = SZ * PER;
    localparam int RDW   = 1 + 2 * SZ + (SZ - 1);
    localparam int CTLW  = 1 + 4 + 1 + 1 + 1 + 2 * SZ;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          abort;
    logic          busy;
    logic          rd_en;
    logic [SZ-1:0] rd_addr_a;
    logic [SZ-1:0] rd_addr_b;
    logic [SZ-2:0] tw_idx;
    logic [3:0]    stage;
    logic          last_stage;
    logic          wr_en;
    logic [SZ-1:0] wr_addr_a;
    logic [SZ-1:0] wr_addr_b;
    logic          done;

    int checks   = 0;
    int failures = 0;

    fft_dif_sequencer #(
        .N       (NN),
        .SIZE    (SZ),
        .LATENCY (LAT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .busy       (busy),
        .rd_en      (rd_en),
        .rd_addr_a  (rd_addr_a),
        .rd_addr_b  (rd_addr_b),
        .tw_idx     (tw_idx),
        .stage      (stage),
        .last_stage (last_stage),
        .wr_en      (wr_en),
        .wr_addr_a  (wr_addr_a),
        .wr_addr_b  (wr_addr_b),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [RDW-1:0]  obs_rd;
    logic [CTLW-1:0] obs_ctl;
    assign obs_rd  = {rd_en, rd_addr_a, rd_addr_b, tw_idx};
    assign obs_ctl = {busy, stage, last_stage, done, wr_en, wr_addr_a, wr_addr_b};

    // Read issued t cycles after the first read of a run: stage = t / PER,
    // position k = t % PER; reads occupy k < HALF, pairs are span apart.
    function automatic logic [RDW-1:0] model_rd(input int t);
        int s, k, span, a, b, tw;
        model_rd = '0;
        if (t >= 0 && t < TDONE) begin
            s = t / PER;
            k = t % PER;
            if (k < HALF) begin
                span = NN >> (s + 1);
                a    = (k / span) * 2 * span + (k % span);
                b    = a + span;
                tw   = ((k % span) * (1 << s)) % HALF;
                model_rd = {1'b1, SZ'(a), SZ'(b), (SZ-1)'(tw)};
            end
        end
    endfunction

    function automatic logic [CTLW-1:0] model_ctl(input int t);
        logic [RDW-1:0] past;
        logic           bsy;
        int             st;
        past = model_rd(t - LAT);
        bsy  = (t <= TDONE);
        st   = (t / PER > SZ - 1) ? SZ - 1 : t / PER;
        return {bsy, 4'(st), bsy && (st == SZ - 1), (t == TDONE),
                past[RDW-1 -: (1 + 2 * SZ)]};
    endfunction

    // Called at the negedge of the first read cycle of a run.
    task automatic check_run(input int last_t, input bit keep_start);
        logic [RDW-1:0]  exp_rd;
        logic [CTLW-1:0] exp_ctl;
        for (int t = 0; t <= last_t; t++) begin
            if (!keep_start) start = 1'b0;
            exp_rd  = model_rd(t);
            exp_ctl = model_ctl(t);
            checks++;
            if (obs_rd !== exp_rd) begin
                failures++;
                $display("FAIL rd_side t=%0d got=%h want=%h {en,a,b,tw}", t, obs_rd, exp_rd);
            end
            checks++;
            if (obs_ctl !== exp_ctl) begin
                failures++;
                $display("FAIL ctl_side t=%0d got=%h want=%h {busy,stage,last,done,wr_en,wa,wb}",
                         t, obs_ctl, exp_ctl);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        #12;
        checks++;
        if ({obs_rd, obs_ctl} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%h want=0", {obs_rd, obs_ctl});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({obs_rd, obs_ctl} !== '0) begin
            failures++;
            $display("FAIL post_reset_idle got=%h want=0", {obs_rd, obs_ctl});
        end
    endtask

    task automatic test_full_run;
        repeat ($urandom_range(1, 5)) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        check_run(TDONE + 1, 1'b0);
    endtask

    task automatic test_abort;
        start = 1'b1;
        @(negedge clk);
        check_run(2 * PER + 2, 1'b0);
        abort = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, rd_en, wr_en, stage, done} !== 8'h00) begin
            failures++;
            $display("FAIL abort_state got=%h want=00 {busy,rd_en,wr_en,stage,done}",
                     {busy, rd_en, wr_en, stage, done});
        end
        abort = 1'b0;
        for (int i = 0; i < 2 * LAT + 2; i++) begin
            @(negedge clk);
            checks++;
            if ({busy, done, wr_en, rd_en} !== 4'h0) begin
                failures++;
                $display("FAIL abort_quiet i=%0d got=%h want=0 {busy,done,wr_en,rd_en}",
                         i, {busy, done, wr_en, rd_en});
            end
        end
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_start_idle got=%b want=0", busy);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL start_not_queued got=%b want=0", busy);
        end
        test_full_run();
    endtask

    task automatic test_back_to_back;
        start = 1'b1;
        @(negedge clk);
        check_run(TDONE + 1, 1'b1);
        check_run(TDONE + 1, 1'b0);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_second got=%b want=0", busy);
        end
    endtask

    task automatic test_reset_mid_drain;
        start = 1'b1;
        @(negedge clk);
        check_run(HALF, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({obs_rd, obs_ctl} !== '0) begin
            failures++;
            $display("FAIL async_reset got=%h want=0", {obs_rd, obs_ctl});
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({obs_rd, obs_ctl} !== '0) begin
                failures++;
                $display("FAIL idle_after_reset i=%0d got=%h want=0", i, {obs_rd, obs_ctl});
            end
        end
        test_full_run();
    endtask

    initial begin
        test_reset();
        test_full_run();
        test_full_run();
        test_abort();
        test_back_to_back();
        test_reset_mid_drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
